// File: rtl/musa_route_pkg.sv
// Shared routing definitions for the MUSA 3-bit-coded 18-bit selection path:
// destination codes, slot count, slot FSM states and the code decoder.
package musa_route_pkg;

  localparam int N_DEST = 6;

  localparam logic [2:0] CODE_D0 = 3'b000;
  localparam logic [2:0] CODE_D1 = 3'b001;
  localparam logic [2:0] CODE_D2 = 3'b010;
  localparam logic [2:0] CODE_D3 = 3'b100;
  localparam logic [2:0] CODE_D4 = 3'b101;
  localparam logic [2:0] CODE_D5 = 3'b110;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] slot;
  } slot_sel_t;

  // Codes 011 and 111 have no destination and come back with valid=0.
  function automatic slot_sel_t code_to_slot(input logic [2:0] code);
    slot_sel_t sel;
    sel.valid = 1'b1;
    sel.slot  = 3'd0;
    case (code)
      CODE_D0: sel.slot = 3'd0;
      CODE_D1: sel.slot = 3'd1;
      CODE_D2: sel.slot = 3'd2;
      CODE_D3: sel.slot = 3'd3;
      CODE_D4: sel.slot = 3'd4;
      CODE_D5: sel.slot = 3'd5;
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/demux3_18_reg_slot.sv
// One destination holding register (module demux_slot) with its EMPTY/FULL FSM.
// The parent only asserts load when the slot is empty or draining this cycle.
module demux_slot
  import musa_route_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load wins over a drain, so a simultaneous drain+load keeps the slot FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (drain && state_q == FULL) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data  = data_q;
  assign valid = (state_q == FULL);

endmodule

// File: rtl/demux3_18_reg.sv
// Registered 18-bit result demultiplexer: routes one coded word per cycle into
// six holding slots. Optional error counter enabled by DEMUX3_18_ERRCNT_EN.
module demux3_18_reg
  import musa_route_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [2:0]               in_ctrl,
  output logic [N_DEST*DATA_W-1:0] out_data,
  output logic [N_DEST-1:0]        out_valid,
  input  logic [N_DEST-1:0]        out_ready,
  output logic                     err,
  output logic [7:0]               err_cnt
);

  slot_sel_t         sel;
  logic [N_DEST-1:0] sel_onehot;
  logic [N_DEST-1:0] slot_load;
  logic              accept;
  logic              err_evt;
  logic              err_q, err_d;

  // Invalid codes never stall: the word is simply dropped and flagged.
  always_comb begin
    sel        = code_to_slot(in_ctrl);
    sel_onehot = '0;
    for (int k = 0; k < N_DEST; k++) begin
      sel_onehot[k] = sel.valid && (sel.slot == 3'(k));
    end
    in_ready  = !sel.valid || |(sel_onehot & (~out_valid | out_ready));
    accept    = in_valid && in_ready;
    slot_load = accept ? sel_onehot : '0;
    err_evt   = accept && !sel.valid;
    err_d     = err_evt;
  end

  for (genvar k = 0; k < N_DEST; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .load_data (in_data),
      .drain     (out_ready[k]),
      .data      (out_data[k*DATA_W +: DATA_W]),
      .valid     (out_valid[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef DEMUX3_18_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/demux3_18_reg.md
# demux3_18_reg

Registered 18-bit result demultiplexer for the MUSA core: takes one 18-bit word tagged with a 3-bit destination code and delivers it to one of six destination ports through a per-port one-entry holding register with valid/ready handshake. It is the distribution end of the 3-bit-coded 18-bit selection path. The datapath uses it to route ALU/memory results to their consumers without combinational fan-out or lost writes under back-pressure.

## Interface
- DATA_W, 18, word width of input and each destination.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DATA_W  word to route.
- in_ctrl  in  3  destination code.
- out_data  out  6*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  6  slot k holds a word.
- out_ready  in  6  consumer k takes its word this cycle.
- err  out  1  one-cycle pulse: an invalid code was accepted.
- err_cnt  out  8  count of invalid codes accepted (see Configuration).

## Operation
- Code-to-slot map: 000->0, 001->1, 010->2, 100->3, 101->4, 110->5. Codes 011 and 111 are invalid.
- Each slot is a two-state FSM, EMPTY and FULL:
  - EMPTY -> FULL on accept to this slot.
  - FULL -> EMPTY on out_ready[k] with no accept to this slot.
  - FULL stays FULL on simultaneous drain and accept; the new word replaces the old one.
- Transfer on the input side: in_valid && in_ready. Transfer on slot k: out_valid[k] && out_ready[k].
- in_ready, combinational:
  - valid code: !out_valid[k] || out_ready[k], where k is the selected slot;
  - invalid code: 1.
- in_ready never depends on in_valid.
- Accepting a valid code loads in_data into slot k's register and sets out_valid[k].
- Accepting an invalid code discards the word, changes no slot, pulses err the next cycle and increments err_cnt.
- err_cnt saturates at 255.
- Only one slot can be loaded per cycle. Any number of slots may drain in the same cycle.
- out_data[k] is stable while out_valid[k]=1 and it is not drained.
- out_data[k] keeps its last value when EMPTY; it is not cleared.

## Timing
- Reset values (asynchronous): out_valid=0, out_data=0, err=0, err_cnt=0, all slots EMPTY. in_ready reflects the empty slots, i.e. 1 during reset.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput: one word per cycle, including repeated writes to the same slot, as long as its consumer holds out_ready=1.
- Full slot with out_ready[k]=0: in_ready=0 for that code. The producer must hold in_data and in_ctrl stable until accept.
- Reset asserted mid-operation: all held words are lost immediately and no partial state survives. The first accept is possible at the first edge after rst_n deasserts.
- in_ctrl or in_data changing while in_valid=0 has no effect.

## Configuration
- DEMUX3_18_ERRCNT_EN defined: err_cnt is an 8-bit saturating counter as described.
- DEMUX3_18_ERRCNT_EN undefined: no counter register, err_cnt tied to 0. The err pulse remains in both builds.

## Structure
- Package musa_route_pkg holds:
  - localparams CODE_D0..CODE_D5 (000, 001, 010, 100, 101, 110);
  - N_DEST=6;
  - function code_to_slot, returning slot index plus a valid flag;
  - typedef slot_state_e {EMPTY, FULL}.
- Sub-module demux_slot: one holding register with its EMPTY/FULL FSM, load/drain inputs and data/valid outputs, instantiated six times by a generate loop.
- The top level keeps the decoder, the in_ready logic and the error path.

## Test plan
- Reset, then in_ctrl=3'b101, in_data=18'h2A5A5, one cycle -> next cycle out_valid=6'b010000, slot 4 data=18'h2A5A5; out_ready[4]=1 -> out_valid=0.
- Slot 0 full with out_ready[0]=0, in_ctrl=000 -> in_ready=0 and data held. Raise out_ready[0] with in_data=18'h00003 -> same edge drains the old word and loads 18'h00003; out_valid[0] stays 1.
- in_ctrl=3'b011, in_valid=1 -> in_ready=1, no out_valid change, err pulses one cycle, err_cnt=1. Repeat 300 times -> err_cnt=255 with the macro, 0 without it.
- Fill all six slots with values 1..6 over six cycles, then assert out_ready=6'b111111 -> all six drain in one cycle with correct per-slot data.
- Back-to-back writes to slot 2 with out_ready[2]=1 held -> one word per cycle, in_ready constantly 1, output sequence matches input.
- rst_n pulled low while slots 1 and 3 are full -> out_valid=0 immediately, without waiting for a clock edge. After release, slot 1 accepts a new word on the first edge.
